// File: rtl/two_source_pixel_arbiter_pkg.sv
// rtl/two_source_pixel_arbiter_pkg.sv - shared types and constants for the two-source pixel arbiter
package two_source_pixel_arbiter_pkg;

  localparam int PIXEL_WIDTH = 24;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_SRC0 = 2'b01;
  localparam logic [1:0] GRANT_SRC1 = 2'b10;

endpackage

// File: rtl/two_source_pixel_arbiter_mux.sv
// rtl/two_source_pixel_arbiter_mux.sv - two-input data multiplexor, Select=1 passes Input1
module TwoInputMultiplexor
  import two_source_pixel_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = PIXEL_WIDTH
) (
  input  logic                  Select,
  input  logic [DATA_WIDTH-1:0] Input0,
  input  logic [DATA_WIDTH-1:0] Input1,
  output logic [DATA_WIDTH-1:0] Output
);

  assign Output = Select ? Input1 : Input0;

endmodule

// File: rtl/two_source_pixel_arbiter.sv
// rtl/two_source_pixel_arbiter.sv - line-granular round-robin arbiter feeding one registered pixel stream
module two_source_pixel_arbiter
  import two_source_pixel_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = PIXEL_WIDTH,
  parameter int MAX_LINE   = 2048,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  InValid0,
  input  logic [DATA_WIDTH-1:0] InData0,
  input  logic                  InLast0,
  output logic                  InReady0,
  input  logic                  InValid1,
  input  logic [DATA_WIDTH-1:0] InData1,
  input  logic                  InLast1,
  output logic                  InReady1,
  output logic                  OutValid,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic                  OutLast,
  input  logic                  OutReady,
  output logic [1:0]            Grant,
  output logic                  Overflow
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_LINE);

  arb_state_e            state_q, state_d;
  logic                  last_owner_q, last_owner_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  overflow_q, overflow_d;

  logic                  load;
  logic                  select;
  logic                  accept;
  logic                  sel_last;
  logic                  hit_max;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic [DATA_WIDTH-1:0] mux_data;

  assign load     = !out_valid_q || OutReady;
  assign select   = (state_q == ARB_GRANT0);
  assign InReady0 = select && load;
  assign InReady1 = (state_q == ARB_GRANT1) && load;
  assign accept   = (InValid0 && InReady0) || (InValid1 && InReady1);
  assign sel_last = select ? InLast0 : InLast1;
  assign cnt_inc  = cnt_q + CNT_WIDTH'(1);
  assign hit_max  = (cnt_inc == MAX_CNT);

  TwoInputMultiplexor #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .Select(select),
    .Input0(InData1),
    .Input1(InData0),
    .Output(mux_data)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    overflow_d   = overflow_q;

    case (state_q)
      ARB_IDLE: begin
        // last_owner_q=1 means source 1 owned last, so source 0 wins a tie
        if (InValid0 && (!InValid1 || last_owner_q)) state_d = ARB_GRANT0;
        else if (InValid1)                          state_d = ARB_GRANT1;
      end
      ARB_GRANT0, ARB_GRANT1: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (sel_last || hit_max) begin
            state_d      = ARB_IDLE;
            last_owner_d = (state_q == ARB_GRANT1);
            cnt_d        = '0;
            if (hit_max && !sel_last) overflow_d = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = sel_last || hit_max;
    end else if (OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      overflow_q   <= overflow_d;
    end
  end

  assign OutValid = out_valid_q;
  assign OutData  = out_data_q;
  assign OutLast  = out_last_q;
  assign Overflow = overflow_q;
  assign Grant    = (state_q == ARB_GRANT0) ? GRANT_SRC0 :
                    (state_q == ARB_GRANT1) ? GRANT_SRC1 : GRANT_NONE;

endmodule

// File: doc/two_source_pixel_arbiter.md
# two_source_pixel_arbiter

Line-granular arbiter that shares one downstream pixel stream between two upstream pixel sources. It steers the existing `TwoInputMultiplexor` with a registered select. It applies valid/ready handshakes on both sides and grants round-robin, one whole line at a time. It sits between two producers (e.g. camera path and overlay/test-pattern path) and a single pixel consumer.

## Interface
Parameters:
- DATA_WIDTH, 24: pixel width in bits.
- MAX_LINE, 2048: maximum beats per grant before forced release.
- CNT_WIDTH, 12: beat-counter width; must satisfy 2^CNT_WIDTH > MAX_LINE.

Ports:
- Clock  in  1  sole clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- InValid0 / InValid1  in  1  source k has a beat.
- InData0 / InData1  in  DATA_WIDTH  source k pixel.
- InLast0 / InLast1  in  1  beat is last pixel of the line.
- InReady0 / InReady1  out  1  arbiter accepts a beat from source k this cycle.
- OutValid  out  1  output register holds a beat.
- OutData  out  DATA_WIDTH  registered pixel.
- OutLast  out  1  registered end-of-line.
- OutReady  in  1  consumer accepts the beat.
- Grant  out  2  one-hot current owner; 00 when idle.
- Overflow  out  1  sticky; a grant hit MAX_LINE without InLast.

## Operation
- FSM states:
  - IDLE: Grant=00, both InReady low.
  - GRANT0 / GRANT1: only the owner's InReady may be high.
- IDLE transitions:
  - Only one InValid high: that source wins.
  - Both high: the source other than LastOwner wins.
  - Neither high: remain in IDLE.
  - LastOwner resets to 1, so source 0 wins the first tie.
- Load condition: load = !OutValid || OutReady.
- InReadyk = (state==GRANTk) && load.
- Accept = InValidk && InReadyk. On Accept:
  - The output register loads InDatak/InLastk through TwoInputMultiplexor (Select=1 chooses source 0 on Input1).
  - The beat counter increments.
- Release from GRANTk to IDLE, setting LastOwner=k and clearing the counter, when either:
  - an Accept carries InLast=1; or
  - an Accept makes the counter equal MAX_LINE. The output beat's OutLast is then forced to 1 and Overflow is set.
- When OutReady is high and there is no Accept, OutValid clears.
- Overflow clears only on reset.
- No beat is ever dropped or duplicated.
- Output order equals acceptance order.

## Timing
- Reset values:
  - State=IDLE, Grant=00, LastOwner=1, counter=0.
  - OutValid=0, OutData=0, OutLast=0, Overflow=0.
  - InReady0=InReady1=0.
- Arbitration is registered. With InValid asserted in IDLE at cycle n:
  - Grant is one-hot from cycle n+1.
  - The first Accept is possible at cycle n+1.
  - OutValid is high at n+2.
- Throughput: one beat per cycle while OutReady stays high.
- Release costs exactly one idle arbitration cycle between lines.
- Backpressure: when OutValid=1 and OutReady=0, InReady of the owner is low and the output register holds stable.
- Owner's InValid low mid-line: grant is held indefinitely; no timeout applies besides MAX_LINE beats.
- Non-owner valid: asserting it has no effect until IDLE.
- Reset asserted mid-line:
  - All outputs return to reset values immediately (asynchronous).
  - The partial line is discarded.
  - After deassertion, arbitration restarts from IDLE with source 0 favoured.

## Structure
- Shared package holds:
  - the FSM state encoding (ARB_IDLE, ARB_GRANT0, ARB_GRANT1);
  - the PIXEL_WIDTH=24 default constant;
  - the one-hot grant constants.
- One sub-module: `TwoInputMultiplexor` (DATA_WIDTH passed through), driven by Select = (state==GRANT0).
- FSM, counter and output register are local to this block.

## Test plan
- Single source: source 0 sends a 4-beat line (0x000001..0x000004, last on beat 4) with OutReady=1. Output shows the same 4 beats with OutLast on the 4th, Grant=01 for 4 cycles, then 00.
- Tie: both valid at cycle 0 from reset. Source 0 line goes out first, then source 1 line; a second tie grants source 0 again only after source 1 has owned.
- Backpressure: hold OutReady=0 for 3 cycles mid-line. OutData/OutValid stay stable, InReady0=0, and no beat is lost or duplicated.
- Overflow: with MAX_LINE=8, source 1 sends 10 beats without last. Beat 8 exits with OutLast=1, Overflow=1 and Grant goes to 00; the remaining 2 beats form a new grant.
- Reset mid-line: assert Reset_n=0 during beat 2 of a line. All outputs are reset the same cycle; after release, source 0 wins the first tie.
- Idle owner: source 0 drops InValid for 5 cycles mid-line while source 1 is valid. Grant stays 01 and source 1 receives no InReady.
